rr_arbiter: RTL and testbench
=============================

RR_ARBITER -- requirements
Module: rr_arbiter

Interface
REQ-001 SHALL have parameter W, default 4, meaning the number of requesters (legal range 2..256).
REQ-002 SHALL have port clk  input  1  system clock, all state rising-edge.
REQ-003 SHALL have port rst_n  input  1  reset; synchronous, active-low.
REQ-004 SHALL have port req_i  input  W  per-requester request level.
REQ-005 SHALL have port ack_i  input  1  consumer accepts the current grant this cycle.
REQ-006 SHALL have port gnt_vld_o  output  1  a grant is outstanding.
REQ-007 SHALL have port gnt_o  output  W  one-hot grant vector; zero when gnt_vld_o is 0.
REQ-008 SHALL have port gnt_idx_o  output  $clog2(W)  binary index of the granted requester.
REQ-009 SHALL have port lock_i  input  1  hold the current grant across ack; present only when RR_ARBITER_LOCK_EN is defined.

Function
REQ-010 SHALL implement a two-state FSM: IDLE (no grant) and BUSY (grant outstanding).
REQ-011 SHALL move IDLE->BUSY on the cycle after any req_i bit is seen high; grant latency is 1 cycle; all outputs are registered.
REQ-012 SHALL hold a priority pointer ptr; requesters at indices strictly above ptr take precedence, lowest such index first.
REQ-013 SHALL choose the winner as the lowest set bit of (req_i AND mask(ptr)); if that is zero, the lowest set bit of req_i (wrap-around).
REQ-014 SHALL hold gnt_o/gnt_idx_o stable in BUSY until ack_i is high, even if the granted req_i bit deasserts or other requests change.
REQ-015 SHALL, on ack_i in BUSY, set ptr to the acked index, then re-arbitrate in that same cycle with the updated ptr; if any req_i bit is high, the next grant is presented the following cycle with no bubble; otherwise go to IDLE.
REQ-016 SHALL re-grant the just-acked requester back-to-back only when it is the sole active requester.
REQ-017 SHALL ignore ack_i in IDLE; ptr is not modified.
REQ-018 SHALL keep gnt_o equal to the one-hot decode of gnt_idx_o whenever gnt_vld_o is 1.

Reset
REQ-019 SHALL, while rst_n is low at a clock edge, drive the FSM to IDLE; gnt_vld_o=0, gnt_o=0, gnt_idx_o=0, ptr=W-1 (requester 0 has highest priority after reset).
REQ-020 SHALL abandon any outstanding grant when reset is asserted mid-BUSY, with no ack required.

Configuration
REQ-021 SHALL, when RR_ARBITER_LOCK_EN is defined, treat ack_i with lock_i high as a lock: the grant stays on the same requester, ptr is unchanged, and the FSM stays in BUSY.
REQ-022 SHALL, when RR_ARBITER_LOCK_EN is undefined, omit the lock_i port; every ack_i releases the grant per REQ-015.

Structure
REQ-023 SHALL place the FSM state enum (IDLE, BUSY) in package rr_arbiter_pkg.
REQ-024 SHALL instantiate the common mask generator maske (W=W, P_INCLUSIVE=0, LEFT_NOT_RIGHT=1) to derive mask(ptr); the priority pick stays local.

Verification (W=4)
REQ-025 SHALL check reset: rst_n=0 for 2 cycles with req_i=4'b1111 -> gnt_vld_o=0, gnt_o=0, gnt_idx_o=0.
REQ-026 SHALL check fairness: req_i=4'b1111 held, ack_i=1 every BUSY cycle -> gnt_idx_o sequence 0,1,2,3,0 on consecutive cycles.
REQ-027 SHALL check single requester: req_i=4'b0100, ack every cycle -> gnt_idx_o=2 on every cycle with no bubble.
REQ-028 SHALL check hold: with grant idx 1 outstanding, ack_i=0 for 5 cycles while req_i changes to 4'b1000 -> gnt_o=4'b0010 stays stable; after ack, gnt_o=4'b1000.
REQ-029 SHALL check mid-grant reset: grant idx 2 outstanding, rst_n=0 -> outputs 0 next cycle; then req_i=4'b0011 -> gnt_idx_o=0.
REQ-030 SHALL check lock (RR_ARBITER_LOCK_EN defined): req_i=4'b1111, grant idx 2, ack_i=1 with lock_i=1 -> idx 2 held; then ack_i=1 with lock_i=0 -> gnt_idx_o=3.

Source files
------------

// File: rtl/rr_arbiter_pkg.sv
// rr_arbiter_pkg -- shared types for the round-robin arbiter.
//   state_t : arbiter FSM state (IDLE = no grant, BUSY = grant outstanding)
package rr_arbiter_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_t;

endpackage

// File: rtl/maske.sv
// maske -- common priority mask generator.
//   Parameters:
//     W              : vector width
//     P_INCLUSIVE    : 1 = include bit ptr itself in the mask
//     LEFT_NOT_RIGHT : 1 = mask bits above ptr, 0 = mask bits below ptr
//   Ports:
//     ptr  in  $clog2(W)  pivot index
//     mask out W          selected bit positions
module maske #(
   parameter int unsigned W              = 4,
   parameter bit          P_INCLUSIVE    = 1'b0,
   parameter bit          LEFT_NOT_RIGHT = 1'b1
) (
   input  logic [$clog2(W)-1:0] ptr,
   output logic [W-1:0]         mask
);

   always_comb begin
      mask = '0;
      for (int unsigned i = 0; i < W; i++) begin
         if (LEFT_NOT_RIGHT)
            mask[i] = (i > 32'(ptr)) || (P_INCLUSIVE && (i == 32'(ptr)));
         else
            mask[i] = (i < 32'(ptr)) || (P_INCLUSIVE && (i == 32'(ptr)));
      end
   end

endmodule

// File: rtl/rr_arbiter.sv
// rr_arbiter -- round-robin arbiter with registered one-hot and binary grant.
//   Optional feature macro: RR_ARBITER_LOCK_EN (adds lock_i; ack with lock
//   keeps the grant on the same requester).
//   Ports:
//     clk        in   1          system clock, rising edge
//     rst_n      in   1          synchronous active-low reset
//     req_i      in   W          request levels
//     ack_i      in   1          consumer accepts current grant
//     lock_i     in   1          hold grant across ack (RR_ARBITER_LOCK_EN only)
//     gnt_vld_o  out  1          grant outstanding
//     gnt_o      out  W          one-hot grant, zero when not valid
//     gnt_idx_o  out  $clog2(W)  binary index of granted requester
module rr_arbiter
   import rr_arbiter_pkg::*;
#(
   parameter int unsigned W = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [W-1:0]         req_i,
   input  logic                 ack_i,
`ifdef RR_ARBITER_LOCK_EN
   input  logic                 lock_i,
`endif
   output logic                 gnt_vld_o,
   output logic [W-1:0]         gnt_o,
   output logic [$clog2(W)-1:0] gnt_idx_o
);

   localparam int unsigned IW = $clog2(W);

   state_t         state, state_nxt;
   logic [IW-1:0]  ptr, ptr_nxt, idx_nxt, ptr_arb, win;
   logic [W-1:0]   mask, masked, cand, gnt_nxt;
   logic           lock, rel, found;

`ifdef RR_ARBITER_LOCK_EN
   assign lock = lock_i;
`else
   assign lock = 1'b0;
`endif

   // A releasing ack moves the pointer to the acked index in the same cycle,
   // so arbitration must already use that index as its pivot.
   assign rel     = (state == BUSY) && ack_i && !lock;
   assign ptr_arb = rel ? gnt_idx_o : ptr;

   maske #(
      .W              (W),
      .P_INCLUSIVE    (1'b0),
      .LEFT_NOT_RIGHT (1'b1)
   ) u_maske (
      .ptr  (ptr_arb),
      .mask (mask)
   );

   // Lowest set bit above the pivot, else wrap to the lowest set bit overall.
   always_comb begin
      masked = req_i & mask;
      cand   = (|masked) ? masked : req_i;
      win    = '0;
      found  = 1'b0;
      for (int unsigned i = 0; i < W; i++) begin
         if (cand[i] && !found) begin
            win   = IW'(i);
            found = 1'b1;
         end
      end
   end

   always_comb begin
      state_nxt = state;
      ptr_nxt   = ptr;
      idx_nxt   = gnt_idx_o;
      case (state)
         IDLE: begin
            if (|req_i) begin
               state_nxt = BUSY;
               idx_nxt   = win;
            end
         end
         BUSY: begin
            if (rel) begin
               ptr_nxt = gnt_idx_o;
               if (|req_i)
                  idx_nxt = win;
               else
                  state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
      gnt_nxt = '0;
      if (state_nxt == BUSY)
         gnt_nxt[idx_nxt] = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         ptr       <= IW'(W - 1);
         gnt_idx_o <= '0;
         gnt_o     <= '0;
      end else begin
         state     <= state_nxt;
         ptr       <= ptr_nxt;
         gnt_idx_o <= idx_nxt;
         gnt_o     <= gnt_nxt;
      end
   end

   assign gnt_vld_o = (state == BUSY);

endmodule

// File: tb/tb_rr_arbiter.sv
// tb_rr_arbiter -- self-checking bench for rr_arbiter (W=4): directed vector
// table, hand-written multi-cycle sequences, and randomized traffic checked
// against a rotating-search reference model.
module tb_rr_arbiter;

   localparam int unsigned W  = 4;
   localparam int unsigned IW = $clog2(W);
`ifdef RR_ARBITER_LOCK_EN
   localparam bit LOCK_EN = 1'b1;
`else
   localparam bit LOCK_EN = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst_n;
   logic [W-1:0]  req;
   logic          ack;
   logic          lock;
   logic          gnt_vld;
   logic [W-1:0]  gnt;
   logic [IW-1:0] gnt_idx;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   rr_arbiter #(.W(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_i     (req),
      .ack_i     (ack),
`ifdef RR_ARBITER_LOCK_EN
      .lock_i    (lock),
`endif
      .gnt_vld_o (gnt_vld),
      .gnt_o     (gnt),
      .gnt_idx_o (gnt_idx)
   );

   // Reference model: grant state plus priority pointer.
   bit          m_vld;
   int unsigned m_idx;
   int unsigned m_ptr;

   // Walk forward from the pointer, wrapping, and take the first requester.
   function automatic int unsigned rr_pick(int unsigned p, logic [W-1:0] r);
      for (int unsigned k = 1; k <= W; k++) begin
         int unsigned j;
         j = (p + k) % W;
         if (r[j]) return j;
      end
      return 0;
   endfunction

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      if (!rst_n) begin
         m_vld = 1'b0;
         m_idx = 0;
         m_ptr = W - 1;
      end else if (!m_vld) begin
         if (req != '0) begin
            m_vld = 1'b1;
            m_idx = rr_pick(m_ptr, req);
         end
      end else if (ack && !(LOCK_EN && lock)) begin
         m_ptr = m_idx;
         if (req != '0) m_idx = rr_pick(m_ptr, req);
         else           m_vld = 1'b0;
      end
      #1;
   endtask

   task automatic check_model(string tag);
      logic [W-1:0] g;
      g = '0;
      if (m_vld) g[m_idx] = 1'b1;
      check({tag, "_vld"}, 32'(gnt_vld), 32'(m_vld));
      check({tag, "_idx"}, 32'(gnt_idx), m_idx);
      check({tag, "_gnt"}, 32'(gnt), 32'(g));
   endtask

   task automatic expect_out(string tag, logic v, logic [IW-1:0] i, logic [W-1:0] g);
      check({tag, "_vld"}, 32'(gnt_vld), 32'(v));
      check({tag, "_idx"}, 32'(gnt_idx), 32'(i));
      check({tag, "_gnt"}, 32'(gnt), 32'(g));
   endtask

   typedef struct {
      logic          rst_n;
      logic [W-1:0]  req;
      logic          ack;
      logic          vld;
      logic [IW-1:0] idx;
      logic [W-1:0]  gnt;
   } vec_t;

   vec_t tbl[11];

   initial begin
      rst_n = 1'b0;
      req   = '0;
      ack   = 1'b0;
      lock  = 1'b0;
      m_vld = 1'b0;
      m_idx = 0;
      m_ptr = W - 1;

      // reset with all requests, fairness sweep, then single requester
      tbl[0]  = '{1'b0, 4'b1111, 1'b0, 1'b0, 2'd0, 4'b0000};
      tbl[1]  = '{1'b0, 4'b1111, 1'b0, 1'b0, 2'd0, 4'b0000};
      tbl[2]  = '{1'b1, 4'b1111, 1'b1, 1'b1, 2'd0, 4'b0001};
      tbl[3]  = '{1'b1, 4'b1111, 1'b1, 1'b1, 2'd1, 4'b0010};
      tbl[4]  = '{1'b1, 4'b1111, 1'b1, 1'b1, 2'd2, 4'b0100};
      tbl[5]  = '{1'b1, 4'b1111, 1'b1, 1'b1, 2'd3, 4'b1000};
      tbl[6]  = '{1'b1, 4'b1111, 1'b1, 1'b1, 2'd0, 4'b0001};
      tbl[7]  = '{1'b1, 4'b0100, 1'b1, 1'b1, 2'd2, 4'b0100};
      tbl[8]  = '{1'b1, 4'b0100, 1'b1, 1'b1, 2'd2, 4'b0100};
      tbl[9]  = '{1'b1, 4'b0100, 1'b1, 1'b1, 2'd2, 4'b0100};
      tbl[10] = '{1'b1, 4'b0100, 1'b1, 1'b1, 2'd2, 4'b0100};

      for (int i = 0; i < 11; i++) begin
         rst_n = tbl[i].rst_n;
         req   = tbl[i].req;
         ack   = tbl[i].ack;
         step();
         expect_out($sformatf("tbl%0d", i), tbl[i].vld, tbl[i].idx, tbl[i].gnt);
      end

      // hold: grant idx 1, no ack while requests change
      req = 4'b0010; ack = 1'b1;
      step();
      expect_out("hold_setup", 1'b1, 2'd1, 4'b0010);
      req = 4'b1000; ack = 1'b0;
      for (int i = 0; i < 5; i++) begin
         step();
         expect_out($sformatf("hold%0d", i), 1'b1, 2'd1, 4'b0010);
      end
      ack = 1'b1;
      step();
      expect_out("hold_rel", 1'b1, 2'd3, 4'b1000);

      // mid-grant reset: grant idx 2 then reset without ack
      req = 4'b0100; ack = 1'b1;
      step();
      expect_out("mrst_setup", 1'b1, 2'd2, 4'b0100);
      rst_n = 1'b0; ack = 1'b0;
      step();
      expect_out("mrst_rst", 1'b0, 2'd0, 4'b0000);
      rst_n = 1'b1; req = 4'b0011;
      step();
      expect_out("mrst_after", 1'b1, 2'd0, 4'b0001);

`ifdef RR_ARBITER_LOCK_EN
      req = 4'b0100; ack = 1'b1; lock = 1'b0;
      step();
      expect_out("lock_setup", 1'b1, 2'd2, 4'b0100);
      req = 4'b1111; lock = 1'b1;
      step();
      expect_out("lock_hold", 1'b1, 2'd2, 4'b0100);
      lock = 1'b0;
      step();
      expect_out("lock_rel", 1'b1, 2'd3, 4'b1000);
`endif

      // randomized traffic against the model
      rst_n = 1'b0; req = '0; ack = 1'b0; lock = 1'b0;
      step();
      step();
      check_model("rnd_rst");
      rst_n = 1'b1;
      for (int c = 0; c < 3000; c++) begin
         rst_n = ($urandom_range(0, 99) < 2) ? 1'b0 : 1'b1;
         req   = ($urandom_range(0, 3) == 0) ? '0 : W'($urandom);
         ack   = ($urandom_range(0, 9) < 7);
         lock  = LOCK_EN && ($urandom_range(0, 4) == 0);
         step();
         check_model($sformatf("rnd%0d", c));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
